uart_alu_interface: RTL
=======================

Name: uart_alu_interface

Overview:
Sits between the uart receive/transmit pair and the ALU on the Basys3 design. Collects three received bytes per frame (operand A, operand B, opcode) and presents them to the ALU together. It then captures the ALU result and hands it to the uart transmitter with a one-cycle start pulse. A timeout discards partially received frames.

Parameters:
N_BITS, 8, data width of uart bytes, ALU operands and result
N_OP, 6, opcode width; the low N_OP bits of the third byte are used
TIMEOUT, 100000000, clock cycles allowed between bytes inside a frame before the partial frame is discarded
NB_TOUT, 27, timeout counter width; must satisfy 2^NB_TOUT > TIMEOUT

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_done_tick  in  1  one-cycle pulse: a new byte is valid on i_rx_data
i_rx_data  in  N_BITS  received byte
i_tx_done_tick  in  1  one-cycle pulse: transmitter finished its byte
i_alu_result  in  N_BITS  combinational ALU result for o_data_a/o_data_b/o_op
o_data_a  out  N_BITS  registered operand A to ALU
o_data_b  out  N_BITS  registered operand B to ALU
o_op  out  N_OP  registered opcode to ALU
o_tx_start  out  1  one-cycle pulse to transmitter i_ready
o_tx_data  out  N_BITS  byte to transmit; held stable from o_tx_start until the next SEND
o_timeout  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (i_reset=0, asynchronous): state=WAIT_A; all outputs 0; shadow registers A/B and timeout counter 0.
- States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
- WAIT_A: on i_rx_done_tick, shadow_a<=i_rx_data; clear counter; go to WAIT_B.
- WAIT_B: on i_rx_done_tick, shadow_b<=i_rx_data; clear counter; go to WAIT_OP.
- WAIT_OP: on i_rx_done_tick, load atomically in the same edge: o_data_a<=shadow_a, o_data_b<=shadow_b, o_op<=i_rx_data[N_OP-1:0]; go to SEND. The upper byte bits are ignored.
- ALU outputs change only on a completed frame; a partial frame never disturbs o_data_a/b/op.
- SEND (exactly one cycle): o_tx_data<=i_alu_result; o_tx_start<=1 on the next edge only; go to WAIT_TX.
- Latency: o_tx_start is high during the 2nd cycle after the cycle in which the opcode i_rx_done_tick was high.
- WAIT_TX: on i_tx_done_tick go to WAIT_A.
  - If i_rx_done_tick is high in the same cycle, that byte is taken as shadow_a and the state goes to WAIT_B.
- Bytes arriving in SEND, or in WAIT_TX without a simultaneous tx_done, are dropped silently.
- Timeout (WAIT_B and WAIT_OP only): the counter increments each cycle without i_rx_done_tick.
  - When the counter reaches TIMEOUT-1: state<=WAIT_A, counter<=0, o_timeout pulses 1 cycle, shadow regs are kept but unused.
  - If a byte arrives in the same cycle as the counter reaches TIMEOUT-1, the byte wins and no timeout occurs.
- The counter is held at 0 in WAIT_A, SEND and WAIT_TX; it never wraps.
- o_tx_start and o_timeout are never high for more than one consecutive cycle.
- Reset mid-frame or mid-transmit returns to WAIT_A at once; no o_tx_start follows.

Test Plan:
- Normal frame: bytes 0x05, 0x03, 0x20, with a bench ALU model where 0x20 = ADD -> o_data_a=0x05, o_data_b=0x03, o_op=0x20 after the 3rd tick; o_tx_data=0x08 with a 1-cycle o_tx_start exactly 2 cycles after the opcode tick; after i_tx_done_tick the block accepts a new frame.
- Opcode masking: third byte 0xE2 -> o_op=0x22.
- Timeout: TIMEOUT=50; send 0x11, then idle -> o_timeout pulses 50 cycles later, o_data_a unchanged. The next bytes 0x01, 0x02, 0x20 form a fresh frame -> o_tx_data=0x03.
- Byte vs timeout collision: TIMEOUT=50; a byte arrives on the cycle the counter hits 49 -> no o_timeout, state advances.
- Busy drop and overlap: a byte 0x77 arriving in WAIT_TX without tx_done -> ignored; a byte 0x09 arriving in the same cycle as i_tx_done_tick -> becomes operand A (the next frame 0x09, 0x01, ADD gives 0x0A).
- Reset mid-frame: after 0x05, 0x03, assert i_reset low for 2 cycles -> all outputs 0, state WAIT_A; a full frame afterwards completes normally.

Source files
------------

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - frames three uart bytes into ALU operands/opcode and returns the result to the uart transmitter
module uart_alu_interface #(
    parameter int N_BITS  = 8,
    parameter int N_OP    = 6,
    parameter int TIMEOUT = 100000000,
    parameter int NB_TOUT = 27
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done_tick,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_tx_done_tick,
    input  logic [N_BITS-1:0] i_alu_result,
    output logic [N_BITS-1:0] o_data_a,
    output logic [N_BITS-1:0] o_data_b,
    output logic [N_OP-1:0]   o_op,
    output logic              o_tx_start,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [NB_TOUT-1:0] TOUT_LAST = NB_TOUT'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   shadow_a_q, shadow_a_d;
    logic [N_BITS-1:0]   shadow_b_q, shadow_b_d;
    logic [NB_TOUT-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0]   data_a_q, data_a_d;
    logic [N_BITS-1:0]   data_b_q, data_b_d;
    logic [N_OP-1:0]     op_q, op_d;
    logic [N_BITS-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                timeout_q, timeout_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            cnt_q      <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            cnt_q      <= cnt_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        cnt_d      = '0;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            WAIT_A: begin
                if (i_rx_done_tick) begin
                    shadow_a_d = i_rx_data;
                    state_d    = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                if (i_rx_done_tick) begin
                    if (state_q == WAIT_B) begin
                        shadow_b_d = i_rx_data;
                        state_d    = WAIT_OP;
                    end else begin
                        // ALU inputs only change here, so a partial frame never disturbs them
                        data_a_d = shadow_a_q;
                        data_b_d = shadow_b_q;
                        op_d     = i_rx_data[N_OP-1:0];
                        state_d  = SEND;
                    end
                end else if (cnt_q == TOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done_tick) begin
                    if (i_rx_done_tick) begin
                        shadow_a_d = i_rx_data;
                        state_d    = WAIT_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_timeout  = timeout_q;

endmodule
